// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Control unit for a 5-stage F/D/E/M/WB datapath. Decodes the instruction in D, carries a
//   control word through E, M and WB, selects forwarding paths for the E operands, resolves
//   load-use, RAW and branch hazards with stall/flush, and holds the NZVC flags register.
//
// Configuration macro: FORWARDING_EN
//   defined   - M/WB forwarding to E; only load-use stalls for one cycle.
//   undefined - forward selects tied to 00; any RAW against a writer in E, M or WB stalls D.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   opcodeD, rs1D/rs2D/rdD instruction fields in D
//   N, Z, V, C             ALU flags from E (loaded by CMP)
//   PCSelectorF            PC loads the branch target (taken branch in WB)
//   stallF, flushD         hold PC/F-D register; send a bubble into E
//   obtainPCAsR1D          operand 1 read returns PC+8 (branch in D)
//   writeEnableD           register-file write enable for the WB instruction
//   data2SelectorE         operand 2 is the immediate
//   aluControlE            ALU operation for E
//   data1/2ForwardSelectorE 00 register, 01 from M, 10 from WB
//   writeDataEnableM       memory write (STR in M)
//   resultSelectorWB       WB result from memory (LDR)
module pipeline_controller #(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned OPCODEWIDTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODEWIDTH-1:0]  opcodeD,
  input  logic [ADDRESSWIDTH-1:0] rs1D,
  input  logic [ADDRESSWIDTH-1:0] rs2D,
  input  logic [ADDRESSWIDTH-1:0] rdD,
  input  logic                    N,
  input  logic                    Z,
  input  logic                    V,
  input  logic                    C,
  output logic                    PCSelectorF,
  output logic                    stallF,
  output logic                    flushD,
  output logic                    obtainPCAsR1D,
  output logic                    writeEnableD,
  output logic                    data2SelectorE,
  output logic [2:0]              aluControlE,
  output logic [1:0]              data1ForwardSelectorE,
  output logic [1:0]              data2ForwardSelectorE,
  output logic                    writeDataEnableM,
  output logic                    resultSelectorWB
);

  localparam logic [OPCODEWIDTH-1:0] OpAddi = OPCODEWIDTH'(8);
  localparam logic [OPCODEWIDTH-1:0] OpLdr  = OPCODEWIDTH'(9);
  localparam logic [OPCODEWIDTH-1:0] OpStr  = OPCODEWIDTH'(10);
  localparam logic [OPCODEWIDTH-1:0] OpB    = OPCODEWIDTH'(11);
  localparam logic [OPCODEWIDTH-1:0] OpBeq  = OPCODEWIDTH'(12);
  localparam logic [OPCODEWIDTH-1:0] OpBne  = OPCODEWIDTH'(13);
  localparam logic [OPCODEWIDTH-1:0] OpCmp  = OPCODEWIDTH'(14);

  // brCond: 00 always, 01 if Z, 10 if !Z
  typedef struct packed {
    logic                    valid;
    logic                    regWrite;
    logic                    memWrite;
    logic                    memToReg;
    logic                    isBranch;
    logic                    taken;
    logic                    isCmp;
    logic                    immSel;
    logic [1:0]              brCond;
    logic [2:0]              aluCtl;
    logic [ADDRESSWIDTH-1:0] rd;
    logic [ADDRESSWIDTH-1:0] rs1;
    logic [ADDRESSWIDTH-1:0] rs2;
  } ctrlWordT;

  typedef enum logic [1:0] {StRun, StBr, StFlush} stateT;

  ctrlWordT decD, eStage, mStage, wbStage, mNext;
  logic     usesRs1D, usesRs2D;
  logic     loadUse, rawStall, hazard, eTaken;
  logic [3:0] flagsReg;
  stateT    stateReg, stateNext;
  logic [1:0] brCnt, brCntNext;

  // ---------------------------------------------------------------- decode
  always_comb begin
    decD     = '0;
    usesRs1D = 1'b0;
    usesRs2D = 1'b0;
    decD.valid = 1'b1;
    decD.rd    = rdD;
    decD.rs1   = rs1D;
    decD.rs2   = rs2D;
    if (opcodeD < OpAddi) begin
      decD.regWrite = 1'b1;
      decD.aluCtl   = opcodeD[2:0];
      usesRs1D      = 1'b1;
      usesRs2D      = 1'b1;
    end else begin
      case (opcodeD)
        OpAddi: begin
          decD.regWrite = 1'b1;
          decD.immSel   = 1'b1;
          usesRs1D      = 1'b1;
        end
        OpLdr: begin
          decD.regWrite = 1'b1;
          decD.memToReg = 1'b1;
          decD.immSel   = 1'b1;
          usesRs1D      = 1'b1;
        end
        OpStr: begin
          decD.memWrite = 1'b1;
          decD.immSel   = 1'b1;
          usesRs1D      = 1'b1;
          usesRs2D      = 1'b1;
        end
        OpB, OpBeq, OpBne: begin
          decD.isBranch = 1'b1;
          decD.immSel   = 1'b1;
          decD.brCond   = (opcodeD == OpBeq) ? 2'b01 : (opcodeD == OpBne) ? 2'b10 : 2'b00;
        end
        OpCmp: begin
          decD.isCmp  = 1'b1;
          decD.aluCtl = 3'b001;
          usesRs1D    = 1'b1;
          usesRs2D    = 1'b1;
        end
        default: ;  // NOP: valid, no side effects
      endcase
    end
  end

  function automatic logic readsFrom(input ctrlWordT s, input logic u1, input logic u2,
                                     input logic [ADDRESSWIDTH-1:0] a1,
                                     input logic [ADDRESSWIDTH-1:0] a2);
    return s.valid & s.regWrite & ((u1 & (s.rd == a1)) | (u2 & (s.rd == a2)));
  endfunction

  // ---------------------------------------------------------------- hazards
  always_comb begin
    loadUse = eStage.memToReg & readsFrom(eStage, usesRs1D, usesRs2D, rs1D, rs2D);
`ifdef FORWARDING_EN
    rawStall = 1'b0;
`else
    rawStall = readsFrom(eStage, usesRs1D, usesRs2D, rs1D, rs2D)
             | readsFrom(mStage, usesRs1D, usesRs2D, rs1D, rs2D)
             | readsFrom(wbStage, usesRs1D, usesRs2D, rs1D, rs2D);
`endif
    hazard = loadUse | rawStall;
  end

  // ---------------------------------------------------------------- branch FSM
  always_comb begin
    stateNext   = stateReg;
    brCntNext   = brCnt;
    stallF      = 1'b0;
    flushD      = 1'b0;
    PCSelectorF = 1'b0;
    case (stateReg)
      StRun: begin
        stallF = hazard;
        flushD = hazard;
        // A hazard keeps the branch in D; it enters E once the stall clears.
        if (!hazard && decD.isBranch) begin
          stateNext = StBr;
          brCntNext = '0;
        end
      end
      StBr: begin
        stallF = 1'b1;
        flushD = 1'b1;
        if (brCnt == 2'd2) begin
          brCntNext = '0;
          if (wbStage.isBranch && wbStage.taken) begin
            PCSelectorF = 1'b1;
            stateNext   = StFlush;
          end else begin
            stateNext = StRun;
          end
        end else begin
          brCntNext = brCnt + 2'd1;
        end
      end
      StFlush: begin
        flushD    = 1'b1;
        stateNext = StRun;
      end
      default: stateNext = StRun;
    endcase
  end

  // Flags register is read here, so a CMP immediately ahead of a branch is already visible.
  always_comb begin
    eTaken = eStage.valid & eStage.isBranch &
             ((eStage.brCond == 2'b00) |
              ((eStage.brCond == 2'b01) & flagsReg[2]) |
              ((eStage.brCond == 2'b10) & ~flagsReg[2]));
    mNext       = eStage;
    mNext.taken = eTaken;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg <= StRun;
      brCnt    <= '0;
      eStage   <= '0;
      mStage   <= '0;
      wbStage  <= '0;
      flagsReg <= '0;
    end else begin
      stateReg <= stateNext;
      brCnt    <= brCntNext;
      eStage   <= flushD ? '0 : decD;
      mStage   <= mNext;
      wbStage  <= mStage;
      if (eStage.valid && eStage.isCmp) begin
        flagsReg <= {N, Z, V, C};
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  function automatic logic [1:0] forwardSel(input logic [ADDRESSWIDTH-1:0] src,
                                            input ctrlWordT m, input ctrlWordT wb);
    if (m.regWrite && !m.memToReg && (m.rd == src)) return 2'b01;
    if (wb.regWrite && (wb.rd == src))              return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    obtainPCAsR1D    = decD.isBranch;
    writeEnableD     = wbStage.regWrite & wbStage.valid;
    resultSelectorWB = wbStage.memToReg;
    writeDataEnableM = mStage.memWrite;
    data2SelectorE   = eStage.immSel;
    aluControlE      = eStage.aluCtl;
`ifdef FORWARDING_EN
    data1ForwardSelectorE = forwardSel(eStage.rs1, mStage, wbStage);
    data2ForwardSelectorE = forwardSel(eStage.rs2, mStage, wbStage);
`else
    data1ForwardSelectorE = 2'b00;
    data2ForwardSelectorE = 2'b00;
`endif
  end

  // Collects stage-word fields that not every stage consumes.
  logic unusedBits;
  assign unusedBits = ^{flagsReg, eStage, mStage, wbStage};

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcodeD = 4'd15, rs1D = '0, rs2D = '0, rdD = '0;
  logic       N = 1'b0, Z = 1'b0, V = 1'b0, C = 1'b0;
  logic       PCSelectorF, stallF, flushD, obtainPCAsR1D, writeEnableD, data2SelectorE;
  logic [2:0] aluControlE;
  logic [1:0] data1ForwardSelectorE, data2ForwardSelectorE;
  logic       writeDataEnableM, resultSelectorWB;

  pipeline_controller dut (
    .clock                (clock),
    .reset                (reset),
    .opcodeD              (opcodeD),
    .rs1D                 (rs1D),
    .rs2D                 (rs2D),
    .rdD                  (rdD),
    .N                    (N),
    .Z                    (Z),
    .V                    (V),
    .C                    (C),
    .PCSelectorF          (PCSelectorF),
    .stallF               (stallF),
    .flushD               (flushD),
    .obtainPCAsR1D        (obtainPCAsR1D),
    .writeEnableD         (writeEnableD),
    .data2SelectorE       (data2SelectorE),
    .aluControlE          (aluControlE),
    .data1ForwardSelectorE(data1ForwardSelectorE),
    .data2ForwardSelectorE(data2ForwardSelectorE),
    .writeDataEnableM     (writeDataEnableM),
    .resultSelectorWB     (resultSelectorWB)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcSel, stall, flush, obtainPc, we, d2Sel;
    logic [2:0] alu;
    logic [1:0] f1, f2;
    logic       memWr, resSel;
  } outT;

  typedef struct packed {
    bit       v;
    bit [3:0] op, rd, rs1, rs2;
    bit       taken;
  } instT;

  // Reference model: instructions in flight in E, M, WB, plus branch progress.
  instT     mE, mM, mW;
  bit [3:0] mFlags;
  int       mode;   // 0 issuing, 1 waiting on branch, 2 redirect flush
  int       brAge;  // cycles since the branch entered E
  int       forceZ = -1;
  outT      expQ[$];
  int       checks = 0, errors = 0;

  function automatic bit writesReg(instT x);  return x.v && x.op <= 4'd9; endfunction
  function automatic bit loadsMem(instT x);   return x.v && x.op == 4'd9; endfunction
  function automatic bit isBr(bit [3:0] op);  return op >= 4'd11 && op <= 4'd13; endfunction
  function automatic bit uses1(bit [3:0] op); return op <= 4'd10 || op == 4'd14; endfunction
  function automatic bit uses2(bit [3:0] op); return op <= 4'd7 || op == 4'd10 || op == 4'd14;
  endfunction

  function automatic bit depends(instT w, bit [3:0] op, bit [3:0] r1, bit [3:0] r2);
    return writesReg(w) && ((uses1(op) && w.rd == r1) || (uses2(op) && w.rd == r2));
  endfunction

  function automatic bit [1:0] fsel(bit [3:0] r);
    if (writesReg(mM) && !loadsMem(mM) && mM.rd == r) return 2'b01;
    if (writesReg(mW) && mW.rd == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic outT predict(bit rst, bit [3:0] op, bit [3:0] r1, bit [3:0] r2,
                                  output bit hazard);
    outT o = '0;
    hazard = 1'b0;
    o.obtainPc = isBr(op);
    if (!rst) return o;
    hazard = loadsMem(mE) && depends(mE, op, r1, r2);
`ifndef FORWARDING_EN
    hazard = hazard || depends(mE, op, r1, r2) || depends(mM, op, r1, r2)
                    || depends(mW, op, r1, r2);
`endif
    case (mode)
      0: begin o.stall = hazard; o.flush = hazard; end
      1: begin o.stall = 1'b1; o.flush = 1'b1; end
      default: o.flush = 1'b1;
    endcase
    o.pcSel  = mW.v && isBr(mW.op) && mW.taken;
    o.we     = writesReg(mW);
    o.resSel = loadsMem(mW);
    o.memWr  = mM.v && mM.op == 4'd10;
    o.d2Sel  = mE.v && mE.op >= 4'd8 && mE.op <= 4'd13;
    if (mE.v && mE.op < 4'd8) o.alu = mE.op[2:0];
    else if (mE.v && mE.op == 4'd14) o.alu = 3'd1;
`ifdef FORWARDING_EN
    o.f1 = fsel(mE.rs1);
    o.f2 = fsel(mE.rs2);
`endif
    return o;
  endfunction

  task automatic advance(bit rst, bit [3:0] op, bit [3:0] rd, bit [3:0] r1, bit [3:0] r2,
                         bit [3:0] nzvc, bit hazard, outT o);
    bit tk;
    if (!rst) begin
      mE = '0; mM = '0; mW = '0; mFlags = '0; mode = 0; brAge = 0;
      return;
    end
    tk = mE.v && isBr(mE.op) &&
         (mE.op == 4'd11 || (mE.op == 4'd12 && mFlags[2]) || (mE.op == 4'd13 && !mFlags[2]));
    case (mode)
      0: if (!hazard && isBr(op)) begin mode = 1; brAge = 1; end
      1: if (brAge == 3) mode = (mW.v && isBr(mW.op) && mW.taken) ? 2 : 0;
         else brAge++;
      default: mode = 0;
    endcase
    if (mE.v && mE.op == 4'd14) mFlags = nzvc;
    mW = mM;
    mM = mE;
    mM.taken = tk;
    mE = o.flush ? '0 : '{v: 1'b1, op: op, rd: rd, rs1: r1, rs2: r2, taken: 1'b0};
  endtask

  // One clock cycle: drive, queue the expected outputs, clock, update the model.
  task automatic step(bit rst, bit [3:0] op, bit [3:0] rd, bit [3:0] r1, bit [3:0] r2,
                      bit [3:0] nzvc, output bit stalled);
    outT o;
    bit  hz;
    reset = rst; opcodeD = op; rdD = rd; rs1D = r1; rs2D = r2; {N, Z, V, C} = nzvc;
    o = predict(rst, op, r1, r2, hz);
    expQ.push_back(o);
    stalled = o.stall;
    @(posedge clock); #1;
    advance(rst, op, rd, r1, r2, nzvc, hz, o);
  endtask

  // Holds the instruction in D for as long as the model says D is stalled.
  task automatic issue(bit [3:0] op, bit [3:0] rd, bit [3:0] r1, bit [3:0] r2);
    bit       st;
    bit [3:0] nz;
    for (int k = 0; k < 8; k++) begin
      nz = 4'($urandom);
      if (forceZ >= 0) nz[2] = forceZ[0];
      step(1'b1, op, rd, r1, r2, nz, st);
      if (!st) return;
    end
    errors++;
    $display("FAIL issue-timeout op=%0d got still-stalled required issued within 8 cycles", op);
  endtask

  task automatic doReset(int n);
    bit st;
    for (int k = 0; k < n; k++) step(1'b0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, st);
  endtask

  // Monitor: compares every sampled cycle against the oldest queued expectation.
  initial begin
    outT a, e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = {PCSelectorF, stallF, flushD, obtainPCAsR1D, writeEnableD, data2SelectorE,
             aluControlE, data1ForwardSelectorE, data2ForwardSelectorE,
             writeDataEnableM, resultSelectorWB};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got %b required %b (pcSel,stall,flush,obtPc,we,d2,alu,f1,f2,mw,rs)",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    bit st;
    mE = '0; mM = '0; mW = '0; mFlags = '0; mode = 0; brAge = 0;
    @(posedge clock); #1;
    doReset(3);
    // ADD r1,r2,r3 ; SUB r4,r1,r5
    issue(4'd0, 4'd1, 4'd2, 4'd3);
    issue(4'd1, 4'd4, 4'd1, 4'd5);
    // ADD r1 ; NOP ; OR r6,r1,r1
    issue(4'd0, 4'd1, 4'd2, 4'd3);
    issue(4'd15, 4'd0, 4'd0, 4'd0);
    issue(4'd3, 4'd6, 4'd1, 4'd1);
    // LDR r2 ; ADD r3,r2,r4
    issue(4'd9, 4'd2, 4'd7, 4'd8);
    issue(4'd0, 4'd3, 4'd2, 4'd4);
    // CMP r1,r1 with Z=1 ; BEQ taken
    forceZ = 1;
    issue(4'd14, 4'd0, 4'd1, 4'd1);
    issue(4'd12, 4'd0, 4'd0, 4'd0);
    issue(4'd0, 4'd9, 4'd10, 4'd11);
    issue(4'd15, 4'd0, 4'd0, 4'd0);
    // CMP Z=1 ; BNE not taken ; held ADD issues after the wait
    issue(4'd14, 4'd0, 4'd2, 4'd2);
    issue(4'd13, 4'd0, 4'd0, 4'd0);
    issue(4'd0, 4'd12, 4'd13, 4'd14);
    forceZ = -1;
    // Reset asserted mid-branch
    issue(4'd11, 4'd0, 4'd0, 4'd0);
    step(1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, st);
    doReset(1);
    issue(4'd15, 4'd0, 4'd0, 4'd0);
    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 63) == 0) doReset(1);
      else issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 6; i++) issue(4'd15, 4'd0, 4'd0, 4'd0);
    @(negedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
